// File: rtl/fabric_mem_rsp.sv
// Tile-local word memory that answers fabric RD requests with RD_RSP transactions through a small FIFO.
// Transaction packing (102 bits): {address[31:0], opcode[1:0], data[31:0], requestorId[31:0], nextTileFifoArbId[3:0]}.
module fabric_mem_rsp #(
    parameter int unsigned MEM_BYTES      = 4096,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Rst,
    input  logic [7:0]   local_tile_id,
    input  logic         InReqValid,
    input  logic [101:0] InReq,
    output logic         InReqReady,
    output logic         OutRspValid,
    output logic [101:0] OutRsp,
    input  logic         OutRspReady,
    output logic [7:0]   IllegalCnt
);

    localparam int unsigned ADDR_BITS = $clog2(MEM_BYTES);
    localparam int unsigned WORDS     = MEM_BYTES / 4;
    localparam int unsigned PTR_BITS  = $clog2(RSP_FIFO_DEPTH);
    localparam logic [PTR_BITS:0] DEPTH_V = RSP_FIFO_DEPTH[PTR_BITS:0];

    typedef enum logic [1:0] {
        OP_RD     = 2'd0,
        OP_WR     = 2'd1,
        OP_RD_RSP = 2'd2,
        OP_WR_RSP = 2'd3
    } t_opcode;

    logic [31:0]          reqAddr;
    t_opcode              reqOp;
    logic [31:0]          reqData;
    logic [3:0]           reqArb;
    logic [ADDR_BITS-3:0] reqIdx;
    logic                 unusedReqBits;

    assign reqAddr       = InReq[101:70];
    assign reqOp         = t_opcode'(InReq[69:68]);
    assign reqData       = InReq[67:36];
    assign reqArb        = InReq[3:0];
    assign reqIdx        = reqAddr[ADDR_BITS-1:2];
    assign unusedReqBits = ^InReq[35:4];

    logic accept, wrEn, rdEn, illegalEn;

    assign accept    = InReqValid && InReqReady;
    assign wrEn      = accept && (reqOp == OP_WR);
    assign rdEn      = accept && (reqOp == OP_RD);
    assign illegalEn = accept && (reqOp != OP_WR) && (reqOp != OP_RD);

    logic [31:0] mem [WORDS];
    logic [31:0] rdData;
    logic [31:0] rdAddr;
    logic [3:0]  rdArb;

    // Synchronous read: a WR one cycle earlier has already landed, so read-after-write needs no bypass.
    always_ff @(posedge Clock) begin
        if (wrEn) begin
            mem[reqIdx] <= reqData;
        end
        if (rdEn) begin
            rdData <= mem[reqIdx];
            rdAddr <= reqAddr;
            rdArb  <= reqArb;
        end
    end

    logic                rdInFlight;
    logic [PTR_BITS-1:0] wrPtr, rdPtr;
    logic [PTR_BITS:0]   fifoCount;
    logic [PTR_BITS:0]   occupancy;
    logic                push, pop;
    logic [101:0]        rspWord;
    logic [101:0]        fifoMem [RSP_FIFO_DEPTH];

    assign push    = rdInFlight;
    assign pop     = OutRspValid && OutRspReady;
    assign rspWord = {local_tile_id, rdAddr[23:0], OP_RD_RSP, rdData, rdAddr, rdArb};

    // Counting the in-flight read reserves its FIFO slot, so the push at the end of T+1 never overflows.
    assign occupancy  = fifoCount + {{PTR_BITS{1'b0}}, rdInFlight};
    assign InReqReady = Rst && (occupancy < DEPTH_V);

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            rdInFlight <= 1'b0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifoCount  <= '0;
            IllegalCnt <= '0;
        end else begin
            rdInFlight <= rdEn;
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: ;
            endcase
            if (illegalEn && (IllegalCnt != 8'hFF)) begin
                IllegalCnt <= IllegalCnt + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifoMem[wrPtr] <= rspWord;
        end
    end

    assign OutRspValid = (fifoCount != '0);
    assign OutRsp      = OutRspValid ? fifoMem[rdPtr] : '0;

endmodule

// File: tb/tb_fabric_mem_rsp.sv
// Randomized and directed bench for fabric_mem_rsp against a queue/array reference model.
module tb_fabric_mem_rsp;

    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned WORDS     = MEM_BYTES / 4;

    localparam logic [1:0] OP_RD     = 2'd0;
    localparam logic [1:0] OP_WR     = 2'd1;
    localparam logic [1:0] OP_RD_RSP = 2'd2;

    logic         Clock = 1'b0;
    logic         Rst = 1'b1;
    logic [7:0]   local_tile_id = 8'h22;
    logic         InReqValid = 1'b0;
    logic [101:0] InReq = '0;
    logic         InReqReady;
    logic         OutRspValid;
    logic [101:0] OutRsp;
    logic         OutRspReady = 1'b1;
    logic [7:0]   IllegalCnt;

    always #5 Clock = ~Clock;

    fabric_mem_rsp #(.MEM_BYTES(MEM_BYTES), .RSP_FIFO_DEPTH(DEPTH)) dut (
        .Clock        (Clock),
        .Rst          (Rst),
        .local_tile_id(local_tile_id),
        .InReqValid   (InReqValid),
        .InReq        (InReq),
        .InReqReady   (InReqReady),
        .OutRspValid  (OutRspValid),
        .OutRsp       (OutRsp),
        .OutRspReady  (OutRspReady),
        .IllegalCnt   (IllegalCnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: every accepted RD not yet popped is outstanding; its response is due two cycles after acceptance.
    typedef struct {
        logic [101:0] word;
        int           acc;
    } t_exp;

    t_exp        expQ[$];
    logic [31:0] modelMem [WORDS];
    int unsigned modelIllegal = 0;
    int          cyc = 0;
    int          popLog[$];

    logic        expValid;
    logic [31:0] mAddr, mData;
    logic [1:0]  mOp;
    int unsigned mIdx;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (!Rst) begin
            checkEq("rstValid", OutRspValid, 0);
            checkEq("rstRsp", OutRsp, 0);
            checkEq("rstReady", InReqReady, 0);
            expQ.delete();
            modelIllegal = 0;
        end else begin
            expValid = (expQ.size() > 0) && (expQ[0].acc + 2 <= cyc);
            checkEq("ready", InReqReady, expQ.size() < DEPTH);
            checkEq("valid", OutRspValid, expValid);
            checkEq("illegalCnt", IllegalCnt, modelIllegal);
            if (OutRspValid && expValid) checkEq("rspWord", OutRsp, expQ[0].word);
            if (OutRspValid && OutRspReady) begin
                if (expQ.size() > 0) void'(expQ.pop_front());
                popLog.push_back(cyc);
            end
            if (InReqValid && InReqReady) begin
                mAddr = InReq[101:70];
                mOp   = InReq[69:68];
                mData = InReq[67:36];
                mIdx  = (mAddr % MEM_BYTES) / 4;
                if (mOp == OP_WR) modelMem[mIdx] = mData;
                else if (mOp == OP_RD)
                    expQ.push_back('{word: {local_tile_id, mAddr[23:0], OP_RD_RSP, modelMem[mIdx], mAddr, InReq[3:0]},
                                     acc: cyc});
                else if (modelIllegal < 255) modelIllegal++;
            end
        end
    end

    function automatic logic [101:0] packReq(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        logic [3:0] arb;
        arb = 4'($urandom);
        return {addr, op, data, 32'hA5A5_5A5A, arb};
    endfunction

    task automatic offer(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                         output bit acc, output int accCyc);
        InReqValid = 1'b1;
        InReq      = packReq(op, addr, data);
        @(negedge Clock);
        acc    = InReqReady;
        accCyc = cyc;
        @(posedge Clock);
        #1;
        InReqValid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data, output int accCyc);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        accCyc = -1;
        while (!acc && tries < 100) begin
            offer(op, addr, data, acc, accCyc);
            tries++;
        end
        checkEq("sendAccepted", acc, 1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 300) begin
            @(negedge Clock);
            n++;
        end
        checkEq("drain", expQ.size(), 0);
        @(posedge Clock);
        #1;
    endtask

    task automatic waitValid(output int seenCyc);
        int n;
        n = 0;
        @(negedge Clock);
        while (!OutRspValid && n < 20) begin
            @(negedge Clock);
            n++;
        end
        checkEq("validSeen", OutRspValid, 1);
        seenCyc = cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          accCyc, seenCyc, accCount, span;
        bit          acc;
        logic [31:0] addr, data;
        logic [31:0] savedAddr [10];
        bit          pending;
        logic [1:0]  pOp;
        logic [31:0] pAddr, pData;
        int unsigned r;

        #1 Rst = 1'b0;
        repeat (3) @(negedge Clock);
        @(posedge Clock);
        #1 Rst = 1'b1;

        for (int unsigned i = 0; i < WORDS; i++) begin
            addr = ($urandom() & 32'hFFFF_F003) | (i << 2);
            send(OP_WR, addr, $urandom(), accCyc);
        end

        // Write then read the same word on the next cycle
        send(OP_WR, 32'h2200_0010, 32'hDEAD_BEEF, accCyc);
        send(OP_RD, 32'h2200_0010, 32'h0, accCyc);
        waitValid(seenCyc);
        checkEq("rawLatency", seenCyc - accCyc, 2);
        checkEq("rawData", OutRsp[67:36], 32'hDEAD_BEEF);
        checkEq("rawAddr", OutRsp[101:70], 32'h2200_0010);
        checkEq("rawOp", OutRsp[69:68], OP_RD_RSP);
        @(posedge Clock);
        #1;
        waitDrain();

        // Backpressure fill
        OutRspReady = 1'b0;
        accCount = 0;
        for (int i = 0; i < 6; i++) begin
            offer(OP_RD, $urandom(), 32'h0, acc, accCyc);
            if (acc) accCount++;
        end
        checkEq("fillAccepted", accCount, 4);
        offer(OP_WR, 32'h0000_0040, 32'h1234_5678, acc, accCyc);
        checkEq("wrBlockedWhenFull", acc, 0);
        OutRspReady = 1'b1;
        send(OP_RD, $urandom(), 32'h0, accCyc);
        send(OP_RD, 32'h0000_0040, 32'h0, accCyc);
        waitDrain();

        // Streaming
        popLog.delete();
        accCount = 0;
        for (int i = 0; i < 16; i++) begin
            offer(OP_RD, $urandom(), 32'h0, acc, accCyc);
            if (acc) accCount++;
        end
        waitDrain();
        checkEq("streamAccepted", accCount, 16);
        checkEq("streamPops", popLog.size(), 16);
        span = (popLog.size() == 16) ? popLog[15] - popLog[0] : -1;
        checkEq("streamSpan", span, 15);

        // Illegal opcodes
        popLog.delete();
        for (int i = 0; i < 300; i++) begin
            addr = $urandom();
            if (i < 10) savedAddr[i] = addr;
            send(OP_RD_RSP, addr, $urandom(), accCyc);
        end
        repeat (3) @(negedge Clock);
        checkEq("illegalSat", IllegalCnt, 8'hFF);
        checkEq("illegalNoRsp", popLog.size(), 0);
        @(posedge Clock);
        #1;
        for (int i = 0; i < 10; i++) send(OP_RD, savedAddr[i], 32'h0, accCyc);
        waitDrain();

        // Address wrap modulo MEM_BYTES
        data = 32'hC0DE_1004;
        send(OP_WR, 32'h0000_1004, data, accCyc);
        send(OP_RD, 32'h0000_0004, 32'h0, accCyc);
        waitValid(seenCyc);
        checkEq("wrapData", OutRsp[67:36], data);
        @(posedge Clock);
        #1;
        waitDrain();

        // Reset with queued responses
        OutRspReady = 1'b0;
        for (int i = 0; i < 3; i++) send(OP_RD, $urandom(), 32'h0, accCyc);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        checkEq("preRstValid", OutRspValid, 1);
        Rst = 1'b0;
        #1;
        checkEq("rstMidValid", OutRspValid, 0);
        checkEq("rstMidReady", InReqReady, 0);
        @(posedge Clock);
        #1;
        Rst = 1'b1;
        popLog.delete();
        OutRspReady = 1'b1;
        @(negedge Clock);
        checkEq("rstRelReady", InReqReady, 1);
        repeat (10) @(negedge Clock);
        checkEq("rstNoRsp", popLog.size(), 0);
        @(posedge Clock);
        #1;

        // Randomized traffic
        local_tile_id = 8'($urandom());
        pending = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            OutRspReady = ($urandom_range(0, 9) < 6);
            if (!pending && $urandom_range(0, 9) < 7) begin
                r = $urandom_range(0, 99);
                pOp = (r < 50) ? OP_RD : (r < 85) ? OP_WR : 2'(2 + $urandom_range(0, 1));
                pAddr = $urandom();
                if ($urandom_range(0, 1) == 1) pAddr = (pAddr & 32'hFFFF_F003) | ($urandom_range(0, 15) << 2);
                pData = $urandom();
                pending = 1'b1;
                InReq = packReq(pOp, pAddr, pData);
            end
            InReqValid = pending;
            @(negedge Clock);
            if (pending && InReqReady) pending = 1'b0;
            @(posedge Clock);
            #1;
            InReqValid = 1'b0;
        end
        OutRspReady = 1'b1;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
